// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline-side request/response and DMem-side signals of the load/store sequencer.
interface lsu_mem_ctrl_if #(
   parameter int ADDR_W = 10
);
   logic              req;
   logic              we;
   logic [2:0]        funct3;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              ready;
   logic              done;
   logic              err;
   logic [31:0]       rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              mem_store;
   logic              mem_load;
   logic [31:0]       mem_dout;

   modport slave (
      input  req, we, funct3, addr, wdata, mem_dout,
      output ready, done, err, rdata, mem_addr, mem_din, mem_store, mem_load
   );

   modport master (
      output req, we, funct3, addr, wdata, mem_dout,
      input  ready, done, err, rdata, mem_addr, mem_din, mem_store, mem_load
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I byte-addressed load/store sequencer over a word-wide DMem with combinational read.
// Sub-word stores are a read-modify-write; loads are lane-aligned and sign/zero extended.
module lsu_mem_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic          clk,
   input  logic          clr_n,
   lsu_mem_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       word_q, word_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [15:0]       ld_shift;
   logic [31:0]       ld_val;
   logic [31:0]       st_word;
   logic              req_bad;
   logic              unused_addr_hi;

   function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic bad_enc;
      bad_enc = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      return bad_enc || (f3[1:0] == 2'b01 && a[0]) || (f3 == 3'd2 && a != 2'b00);
   endfunction

   // Byte address bits above the DMem word range alias onto the same word.
   assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
   assign req_bad        = is_illegal(bus.we, bus.funct3, bus.addr[1:0]);

   always_comb begin
      ld_shift = 16'(bus.mem_dout >> {addr_q[1:0], 3'b000});
      ld_val   = bus.mem_dout;
      case (f3_q)
         3'd0:    ld_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd4:    ld_val = {24'h0, ld_shift[7:0]};
         3'd1:    ld_val = {{16{ld_shift[15]}}, ld_shift};
         3'd5:    ld_val = {16'h0, ld_shift};
         default: ld_val = bus.mem_dout;
      endcase
   end

   always_comb begin
      st_word = wdata_q;
      case (f3_q)
         3'd0: begin
            st_word = word_q;
            st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         3'd1: begin
            st_word = word_q;
            st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: st_word = wdata_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               f3_d    = bus.funct3;
               addr_d  = bus.addr[ADDR_W+1:0];
               wdata_d = bus.wdata;
               rdata_d = '0;
               err_d   = req_bad;
               if (req_bad)                          state_d = S_RESP;
               else if (bus.we && bus.funct3 == 3'd2) state_d = S_WR;
               else                                  state_d = S_RD;
            end
         end
         S_RD: begin
            word_d = bus.mem_dout;
            if (we_q) begin
               state_d = S_WR;
            end else begin
               rdata_d = ld_val;
               state_d = S_RESP;
            end
         end
         S_WR:    state_d = S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.ready     = (state_q == S_IDLE);
   assign bus.done      = (state_q == S_RESP);
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_load  = (state_q == S_RD);
   assign bus.mem_store = (state_q == S_WR);
   assign bus.mem_addr  = (state_q == S_RD || state_q == S_WR) ? addr_q[ADDR_W+1:2] : '0;
   assign bus.mem_din   = (state_q == S_WR) ? st_word : '0;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, abort/back-to-back sequences, random ops vs. a byte-level model.
module tb_lsu_mem_ctrl;
   logic clk = 1'b0;
   logic clr_n;
   int   n_chk = 0;
   int   n_fail = 0;

   lsu_mem_ctrl_if #(.ADDR_W(10)) bus ();
   lsu_mem_ctrl #(.ADDR_W(10)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

   always #5 clk = ~clk;

   logic [31:0] dmem    [0:1023];
   logic [31:0] mdl_mem [0:1023];

   assign bus.mem_dout = bus.mem_load ? dmem[bus.mem_addr] : 32'h0;
   always @(posedge clk) if (bus.mem_store) dmem[bus.mem_addr] <= bus.mem_din;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          lcyc;
      int          scyc;
      logic [31:0] din;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Byte-lane model: memory is treated as a little-endian byte array.
   task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er,
                           output int lat);
      int          nb;
      bit          sgn;
      int          idx;
      int          off;
      logic [63:0] v;
      logic [63:0] mask;
      case (f3)
         3'd0: begin nb = 1; sgn = 1; end
         3'd1: begin nb = 2; sgn = 1; end
         3'd2: begin nb = 4; sgn = 0; end
         3'd4: begin nb = 1; sgn = 0; end
         3'd5: begin nb = 2; sgn = 0; end
         default: begin nb = 0; sgn = 0; end
      endcase
      off = int'(a[1:0]);
      er  = (nb == 0) || (we && f3 > 3'd2);
      if (!er && (off % nb) != 0) er = 1;
      rd  = 32'h0;
      lat = 1;
      if (er) return;
      idx = int'(a[11:2]);
      if (we) begin
         for (int i = 0; i < nb; i++) mdl_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
         lat = (nb == 4) ? 2 : 3;
      end else begin
         mask = (64'd1 << (8*nb)) - 64'd1;
         v    = ({32'h0, mdl_mem[idx]} >> (8*off)) & mask;
         if (sgn && v[8*nb-1]) v = v | ~mask;
         rd  = v[31:0];
         lat = 2;
      end
   endtask

   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int lcyc, output int scyc,
                        output logic [31:0] din, output logic [9:0] maddr, output logic both);
      @(negedge clk);
      bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
      rd = 32'h0; er = 1'b0; lat = 0; lcyc = 0; scyc = 0; din = 32'h0; maddr = '0; both = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.mem_load && bus.mem_store) both = 1'b1;
         if (bus.mem_load && lcyc == 0) begin lcyc = c; maddr = bus.mem_addr; end
         if (bus.mem_store && scyc == 0) begin scyc = c; din = bus.mem_din; maddr = bus.mem_addr; end
         if (bus.done) begin lat = c; rd = bus.rdata; er = bus.err; break; end
      end
      bus.req = 1'b0;
   endtask

   task automatic abort_at(input int phase);
      int dcnt;
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'd0; bus.addr = 32'h10; bus.wdata = 32'h55;
      repeat (phase) @(negedge clk);
      chk($sformatf("abort%0d_load_before", phase), bus.mem_load, phase == 1);
      chk($sformatf("abort%0d_store_before", phase), bus.mem_store, phase == 2);
      #1 clr_n = 1'b0;
      #1;
      chk("abort_ready", bus.ready, 1);
      chk("abort_done", bus.done, 0);
      chk("abort_mem_ctl", {bus.mem_load, bus.mem_store}, 0);
      chk("abort_mem_addr", bus.mem_addr, 0);
      chk("abort_mem_din", bus.mem_din, 0);
      bus.req = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      dcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, erd, din;
      logic        er, eer, both;
      logic [9:0]  maddr;
      int          lat, elat, lcyc, scyc, dcnt;
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] ra, rwd;
      logic [2:0]  ld_ok [5];
      ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      tbl[0]  = '{1'b1, 3'd2, 32'h10,       32'h80FF7F01, 32'h0,        1'b0, 2, 0, 1, 32'h80FF7F01};
      tbl[1]  = '{1'b0, 3'd0, 32'h12,       32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'h0};
      tbl[2]  = '{1'b0, 3'd4, 32'h12,       32'h0,        32'h000000FF, 1'b0, 2, 1, 0, 32'h0};
      tbl[3]  = '{1'b0, 3'd1, 32'h12,       32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h0};
      tbl[4]  = '{1'b0, 3'd5, 32'h12,       32'h0,        32'h000080FF, 1'b0, 2, 1, 0, 32'h0};
      tbl[5]  = '{1'b0, 3'd2, 32'h10,       32'h0,        32'h80FF7F01, 1'b0, 2, 1, 0, 32'h0};
      tbl[6]  = '{1'b0, 3'd0, 32'h11,       32'h0,        32'h0000007F, 1'b0, 2, 1, 0, 32'h0};
      tbl[7]  = '{1'b1, 3'd0, 32'h11,       32'hDEADBEAB, 32'h0,        1'b0, 3, 1, 2, 32'h80FFAB01};
      tbl[8]  = '{1'b0, 3'd2, 32'h10,       32'h0,        32'h80FFAB01, 1'b0, 2, 1, 0, 32'h0};
      tbl[9]  = '{1'b1, 3'd2, 32'h10,       32'h80FF7F01, 32'h0,        1'b0, 2, 0, 1, 32'h80FF7F01};
      tbl[10] = '{1'b1, 3'd1, 32'h12,       32'h00001234, 32'h0,        1'b0, 3, 1, 2, 32'h12347F01};
      tbl[11] = '{1'b0, 3'd2, 32'h10,       32'h0,        32'h12347F01, 1'b0, 2, 1, 0, 32'h0};
      tbl[12] = '{1'b0, 3'd4, 32'h13,       32'h0,        32'h00000012, 1'b0, 2, 1, 0, 32'h0};
      tbl[13] = '{1'b0, 3'd2, 32'h11,       32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
      tbl[14] = '{1'b1, 3'd1, 32'h13,       32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h0};
      tbl[15] = '{1'b0, 3'd3, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
      tbl[16] = '{1'b1, 3'd4, 32'h10,       32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 0, 32'h0};
      tbl[17] = '{1'b0, 3'd1, 32'h13,       32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
      tbl[18] = '{1'b0, 3'd2, 32'hABCD1010, 32'h0,        32'h12347F01, 1'b0, 2, 1, 0, 32'h0};

      clr_n = 1'b0;
      bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
      #1;
      chk("rst_ready", bus.ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_mem_ctl", {bus.mem_load, bus.mem_store}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_din", bus.mem_din, 0);
      #2 clr_n = 1'b1;

      foreach (tbl[i]) begin
         do_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, er, lat, lcyc, scyc, din, maddr, both);
         chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
         chk($sformatf("v%0d_err", i), er, tbl[i].er);
         chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
         chk($sformatf("v%0d_load_cycle", i), lcyc, tbl[i].lcyc);
         chk($sformatf("v%0d_store_cycle", i), scyc, tbl[i].scyc);
         chk($sformatf("v%0d_mutex", i), both, 0);
         if (tbl[i].scyc != 0) chk($sformatf("v%0d_mem_din", i), din, tbl[i].din);
         if (!tbl[i].er) chk($sformatf("v%0d_mem_addr", i), maddr, {22'h0, tbl[i].addr[11:2]});
      end

      // Aborted SB in RD and in WR: the word must stay untouched.
      for (int ph = 1; ph <= 2; ph++) begin
         abort_at(ph);
         do_op(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, lcyc, scyc, din, maddr, both);
         chk($sformatf("abort%0d_word_kept", ph), rd, 32'h12347F01);
      end

      // req held high: one accept per IDLE, done every third cycle.
      @(negedge clk);
      bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'd2; bus.addr = 32'h10;
      dcnt = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         chk($sformatf("hold_c%0d_ready", c), bus.ready, (c % 3) == 0);
         chk($sformatf("hold_c%0d_done", c), bus.done, (c % 3) == 2);
         if (bus.done) begin
            dcnt++;
            chk($sformatf("hold_c%0d_rdata", c), bus.rdata, 32'h12347F01);
         end
      end
      bus.req = 1'b0;
      chk("hold_done_count", dcnt, 4);

      // Random phase over words 16..23 with random aliasing bits.
      for (int w = 16; w < 24; w++) begin
         ra  = ($urandom() & 32'hFFFF_F000) | (w << 2);
         rwd = $urandom();
         model_op(1'b1, 3'd2, ra, rwd, erd, eer, elat);
         do_op(1'b1, 3'd2, ra, rwd, rd, er, lat, lcyc, scyc, din, maddr, both);
         chk("init_latency", lat, elat);
      end
      for (int n = 0; n < 300; n++) begin
         rwe = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) rf3 = 3'($urandom_range(0, 7));
         else if (rwe)                  rf3 = 3'($urandom_range(0, 2));
         else                           rf3 = ld_ok[$urandom_range(0, 4)];
         ra  = ($urandom() & 32'hFFFF_F000) | ($urandom_range(16, 23) << 2) | $urandom_range(0, 3);
         rwd = $urandom();
         model_op(rwe, rf3, ra, rwd, erd, eer, elat);
         do_op(rwe, rf3, ra, rwd, rd, er, lat, lcyc, scyc, din, maddr, both);
         chk($sformatf("rnd%0d_rdata", n), rd, erd);
         chk($sformatf("rnd%0d_err", n), er, eer);
         chk($sformatf("rnd%0d_latency", n), lat, elat);
         if (eer) chk($sformatf("rnd%0d_err_no_mem", n), {31'h0, (lcyc != 0) || (scyc != 0)}, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
